// File: rtl/cpuc_sequencer.sv
// Program sequencer for the CPUC datapath: steps a PC through a host-loaded program and
// drives the register-file write-enable mask on each issue cycle.
module cpuc_sequencer #(
    parameter int unsigned NUM_OF_REGS  = 32,
    parameter int unsigned NUM_OF_CMP   = 16,
    parameter int unsigned PROGRAM_SIZE = 32,
    parameter int unsigned DELAY_W      = 4,
    localparam int unsigned PC_W        = $clog2(PROGRAM_SIZE),
    localparam int unsigned CMP_W       = $clog2(NUM_OF_CMP),
    localparam int unsigned INSTR_W     = NUM_OF_REGS + DELAY_W + 3 + CMP_W + PC_W
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   prog_wr_en,
    input  logic [PC_W-1:0]        prog_wr_addr,
    input  logic [INSTR_W-1:0]     prog_wr_data,
    input  logic [NUM_OF_CMP-1:0]  cmp_res,
    output logic [NUM_OF_REGS-1:0] reg_we,
    output logic [PC_W-1:0]        pc,
    output logic                   busy,
    output logic                   done,
    output logic                   load_err,
    output logic [15:0]            retired_cnt
);

    localparam int unsigned TGT_LSB   = 0;
    localparam int unsigned SEL_LSB   = PC_W;
    localparam int unsigned JCOND_BIT = PC_W + CMP_W;
    localparam int unsigned JMP_BIT   = JCOND_BIT + 1;
    localparam int unsigned HALT_BIT  = JCOND_BIT + 2;
    localparam int unsigned DLY_LSB   = JCOND_BIT + 3;
    localparam int unsigned WE_LSB    = DLY_LSB + DELAY_W;
    localparam logic [PC_W-1:0] LAST_PC = PC_W'(PROGRAM_SIZE - 1);

    typedef enum logic [1:0] {StIdle, StRun, StWait, StDone} state_e;

    state_e               state_q;
    logic [DELAY_W-1:0]   wait_cnt_q;
    logic [INSTR_W-1:0]   mem [PROGRAM_SIZE];

    logic [INSTR_W-1:0]     instr;
    logic [NUM_OF_REGS-1:0] instr_we;
    logic [DELAY_W-1:0]     instr_delay;
    logic                   instr_halt;
    logic                   instr_jmp;
    logic                   instr_jcond;
    logic [CMP_W-1:0]       instr_sel;
    logic [PC_W-1:0]        instr_tgt;
    logic                   jump_taken;
    logic                   res_done;
    logic [PC_W-1:0]        res_pc;

    assign busy = (state_q == StRun) || (state_q == StWait);

    // Program store has no reset so a loaded program survives reset and restarts.
    always_ff @(posedge Clk) begin
        if (prog_wr_en && !busy) begin
            mem[prog_wr_addr] <= prog_wr_data;
        end
    end

    assign instr       = mem[pc];
    assign instr_we    = instr[WE_LSB +: NUM_OF_REGS];
    assign instr_delay = instr[DLY_LSB +: DELAY_W];
    assign instr_halt  = instr[HALT_BIT];
    assign instr_jmp   = instr[JMP_BIT];
    assign instr_jcond = instr[JCOND_BIT];
    assign instr_sel   = instr[SEL_LSB +: CMP_W];
    assign instr_tgt   = instr[TGT_LSB +: PC_W];

    assign jump_taken = instr_jmp && (!instr_jcond || cmp_res[instr_sel]);
    assign reg_we     = (state_q == StRun && !abort) ? instr_we : '0;

    // Next-pc resolution, used on the last cycle of an instruction (RUN or final WAIT).
    always_comb begin
        res_done = 1'b0;
        res_pc   = pc + PC_W'(1);
        if (instr_halt) begin
            res_done = 1'b1;
            res_pc   = pc;
        end else if (jump_taken) begin
            res_pc = instr_tgt;
        end else if (pc == LAST_PC) begin
            res_done = 1'b1;
            res_pc   = pc;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= StIdle;
            pc          <= '0;
            wait_cnt_q  <= '0;
            retired_cnt <= '0;
            done        <= 1'b0;
            load_err    <= 1'b0;
        end else begin
            load_err <= prog_wr_en && busy;
            if (abort) begin
                state_q <= StIdle;
                pc      <= '0;
                done    <= 1'b0;
            end else begin
                case (state_q)
                    StIdle, StDone: begin
                        if (start) begin
                            state_q     <= StRun;
                            pc          <= '0;
                            retired_cnt <= '0;
                            done        <= 1'b0;
                        end
                    end
                    StRun: begin
                        if (retired_cnt != 16'hFFFF) begin
                            retired_cnt <= retired_cnt + 16'd1;
                        end
                        if (instr_delay != '0) begin
                            state_q    <= StWait;
                            wait_cnt_q <= instr_delay;
                        end else begin
                            pc      <= res_pc;
                            done    <= res_done;
                            state_q <= res_done ? StDone : StRun;
                        end
                    end
                    StWait: begin
                        wait_cnt_q <= wait_cnt_q - DELAY_W'(1);
                        if (wait_cnt_q == DELAY_W'(1)) begin
                            pc      <= res_pc;
                            done    <= res_done;
                            state_q <= res_done ? StDone : StRun;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cpuc_sequencer.sv
// Bench for cpuc_sequencer: directed scenarios plus random programs, checked every cycle
// against an instruction-level interpreter of the program.
module tb_cpuc_sequencer;

    localparam int NR = 32, NC = 16, PS = 32, PCW = 5, IW = 48;

    logic Clk = 1'b0, Rst_n = 1'b1, start = 1'b0, abort = 1'b0, prog_wr_en = 1'b0;
    logic [PCW-1:0] prog_wr_addr = '0;
    logic [IW-1:0]  prog_wr_data = '0;
    logic [NC-1:0]  cmp_res = '0;
    logic [NR-1:0]  reg_we;
    logic [PCW-1:0] pc;
    logic           busy, done, load_err;
    logic [15:0]    retired_cnt;

    cpuc_sequencer dut (
        .Clk(Clk), .Rst_n(Rst_n), .start(start), .abort(abort), .prog_wr_en(prog_wr_en),
        .prog_wr_addr(prog_wr_addr), .prog_wr_data(prog_wr_data), .cmp_res(cmp_res),
        .reg_we(reg_we), .pc(pc), .busy(busy), .done(done), .load_err(load_err),
        .retired_cnt(retired_cnt)
    );

    always #5 Clk = ~Clk;

    int errors = 0, checks = 0;
    int busy_cycles = 0;

    // Interpreter state: which instruction is current, whether it is in its issue cycle,
    // and how many wait cycles remain before its successor is chosen.
    logic [IW-1:0] m_mem [PS];
    bit m_run, m_issue, m_done, m_lerr;
    int m_pc, m_left, m_ret;

    function automatic logic [IW-1:0] mk(input logic [31:0] we, input int dly, input bit halt,
                                         input bit jen, input bit jc, input int sel,
                                         input int tgt);
        return {we, 4'(dly), halt, jen, jc, 4'(sel), 5'(tgt)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit s, input bit a, input logic [NC-1:0] c, input bit w,
                        input int addr, input logic [IW-1:0] d);
        logic [IW-1:0] ins;
        bit resolve;
        start = s; abort = a; cmp_res = c; prog_wr_en = w;
        prog_wr_addr = 5'(addr); prog_wr_data = d;
        #1;
        ins = m_mem[m_pc];
        chk("reg_we", reg_we, (m_run && m_issue && !a) ? ins[47:16] : 32'h0);
        chk("pc", 32'(pc), 32'(m_pc));
        chk("busy", 32'(busy), 32'(m_run));
        chk("done", 32'(done), 32'(m_done));
        chk("load_err", 32'(load_err), 32'(m_lerr));
        chk("retired_cnt", 32'(retired_cnt), 32'(m_ret));
        if (busy) busy_cycles++;
        @(posedge Clk);
        m_lerr = w && m_run;
        if (w && !m_run) m_mem[addr] = d;
        if (a) begin
            m_run = 0; m_pc = 0; m_done = 0;
        end else if (!m_run) begin
            if (s) begin m_run = 1; m_issue = 1; m_pc = 0; m_ret = 0; m_done = 0; end
        end else begin
            if (m_issue) begin
                m_ret   = (m_ret == 65535) ? 65535 : m_ret + 1;
                m_left  = int'(ins[15:12]);
                m_issue = 0;
                resolve = (m_left == 0);
            end else begin
                resolve = (m_left == 1);
                m_left--;
            end
            if (resolve) begin
                if (ins[11]) begin
                    m_run = 0; m_done = 1;
                end else if (ins[10] && (!ins[9] || c[ins[8:5]])) begin
                    m_pc = int'(ins[4:0]); m_issue = 1;
                end else if (m_pc == PS - 1) begin
                    m_run = 0; m_done = 1;
                end else begin
                    m_pc++; m_issue = 1;
                end
            end
        end
        @(negedge Clk);
        start = 0; abort = 0; prog_wr_en = 0;
    endtask

    task automatic idle(input int n, input logic [NC-1:0] c);
        for (int i = 0; i < n; i++) step(0, 0, c, 0, 0, '0);
    endtask

    task automatic load(input int addr, input logic [IW-1:0] d);
        step(0, 0, '0, 1, addr, d);
    endtask

    task automatic do_reset();
        #2 Rst_n = 1'b0;
        #1;
        chk("rst reg_we", reg_we, 32'h0);
        chk("rst pc", 32'(pc), 32'h0);
        chk("rst busy", 32'(busy), 32'h0);
        chk("rst done", 32'(done), 32'h0);
        chk("rst load_err", 32'(load_err), 32'h0);
        chk("rst retired", 32'(retired_cnt), 32'h0);
        m_run = 0; m_issue = 0; m_done = 0; m_lerr = 0; m_pc = 0; m_left = 0; m_ret = 0;
        @(negedge Clk);
        Rst_n = 1'b1;
    endtask

    initial begin
        @(negedge Clk);
        do_reset();

        // End of program: no halt, runs off slot 31 into DONE without wrapping.
        for (int i = 0; i < PS; i++) load(i, mk(0, 0, 0, 0, 0, 0, 0));
        step(1, 0, '0, 0, 0, '0);
        idle(36, '0);
        chk("eop pc", 32'(pc), 32'd31);
        chk("eop retired", 32'(retired_cnt), 32'd32);
        chk("eop done", 32'(done), 32'd1);

        // Straight line with halt.
        load(0, mk(32'h1, 0, 0, 0, 0, 0, 0));
        load(1, mk(32'h2, 0, 0, 0, 0, 0, 0));
        load(2, mk(32'h4, 0, 1, 0, 0, 0, 0));
        step(1, 0, '0, 0, 0, '0);
        idle(3, '0);
        chk("line done", 32'(done), 32'd1);
        chk("line retired", 32'(retired_cnt), 32'd3);
        chk("line pc", 32'(pc), 32'd2);

        // Delay: busy for delay+2 cycles in total.
        load(0, mk(32'h8, 3, 0, 0, 0, 0, 0));
        load(1, mk(32'h0, 0, 1, 0, 0, 0, 0));
        step(1, 0, '0, 0, 0, '0);
        busy_cycles = 0;
        idle(8, '0);
        chk("delay busy cycles", 32'(busy_cycles), 32'd5);

        // Conditional jump on cmp_res[5], taken then not taken.
        load(0, mk(32'h0, 0, 0, 1, 1, 5, 7));
        load(1, mk(32'h40, 0, 1, 0, 0, 0, 0));
        load(7, mk(32'h80, 0, 1, 0, 0, 0, 0));
        step(1, 0, '0, 0, 0, '0);
        step(0, 0, 16'h0020, 0, 0, '0);
        chk("jmp taken pc", 32'(pc), 32'd7);
        idle(3, '0);
        step(1, 0, '0, 0, 0, '0);
        step(0, 0, 16'hFFDF, 0, 0, '0);
        chk("jmp not taken pc", 32'(pc), 32'd1);
        idle(3, '0);

        // Load while busy is dropped; then reset in the middle of a wait.
        load(0, mk(32'h10, 2, 0, 0, 0, 0, 0));
        load(1, mk(32'h20, 0, 1, 0, 0, 0, 0));
        step(1, 0, '0, 0, 0, '0);
        step(0, 0, '0, 1, 1, mk(32'hFFFF, 0, 1, 0, 0, 0, 0));
        step(0, 0, '0, 0, 0, '0);
        idle(4, '0);
        step(1, 0, '0, 0, 0, '0);
        idle(2, '0);
        do_reset();
        step(1, 0, '0, 0, 0, '0);
        idle(6, '0);
        chk("rerun done", 32'(done), 32'd1);
        chk("rerun retired", 32'(retired_cnt), 32'd2);

        // Random programs with random comparators, aborts, restarts and stray writes.
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < PS; i++)
                load(i, mk($urandom, $urandom_range(0, 3), $urandom_range(0, 9) == 0,
                           $urandom_range(0, 3) == 0, $urandom_range(0, 1),
                           $urandom_range(0, 15), $urandom_range(0, 31)));
            step(1, 0, 16'($urandom), 0, 0, '0);
            for (int k = 0; k < 60; k++)
                step($urandom_range(0, 15) == 0, $urandom_range(0, 49) == 0, 16'($urandom),
                     $urandom_range(0, 9) == 0, $urandom_range(0, 31),
                     {16'($urandom), 32'($urandom)});
            step(0, 1, '0, 0, 0, '0);
        end

        // Self-loop: retired_cnt saturates, abort returns to idle with reg_we masked.
        load(0, mk(32'h1, 0, 0, 1, 0, 0, 0));
        step(1, 0, '0, 0, 0, '0);
        idle(65540, '0);
        chk("sat retired", 32'(retired_cnt), 32'hFFFF);
        chk("loop busy", 32'(busy), 32'd1);
        step(0, 1, '0, 0, 0, '0);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort pc", 32'(pc), 32'd0);
        idle(2, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
